// File: rtl/data_memory_bank.sv
// data_memory_bank: single-port byte-addressed data memory with request/response
// handshake, byte strobes, READ_LATENCY-deep response pipeline, range check and
// post-reset clear. Optional misalignment check: define DMEM_MISALIGN_CHECK_EN.
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_write/req_addr/
// req_wdata/req_wstrb in; rsp_valid/rsp_rdata/rsp_error out; init_busy out.
module data_memory_bank #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    init_busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TOP   = IDX_W + OFF_W;
  localparam int LAT   = READ_LATENCY;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((1 << OFF_W) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic             out_of_range;
  logic             misaligned;
  logic             req_err;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [BYTES-1:0] wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [LAT-1:0]        pv_q, pv_d;
  logic [LAT-1:0]        pe_q, pe_d;
  logic [DATA_WIDTH-1:0] pd_q [LAT];
  logic [DATA_WIDTH-1:0] pd_d [LAT];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Next state: INIT walks every index once, then RUN until reset
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      ST_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST_IDX)
          state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs: reset forces the not-ready view immediately
  always_comb begin
    req_ready = 1'b0;
    init_busy = 1'b1;
    unique case (state_q)
      ST_RUN: begin
        req_ready = !reset;
        init_busy = reset;
      end
      default: begin
        req_ready = 1'b0;
        init_busy = 1'b1;
      end
    endcase
  end

  assign accept       = req_valid && req_ready;
  assign req_idx      = req_addr[TOP-1:OFF_W];
  assign out_of_range = |(req_addr >> TOP);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = |(req_addr & OFF_MASK);
`else
  logic unused_off;
  assign unused_off = |(req_addr & OFF_MASK);
  assign misaligned = 1'b0;
`endif

  assign req_err = out_of_range || misaligned;

  // Single write port shared by the clear walk and stores
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = req_idx;
    wr_be   = req_wstrb;
    wr_data = req_wdata;
    if (reset) begin
      wr_en = 1'b0;
    end else if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = init_idx_q;
      wr_be   = '1;
      wr_data = '0;
    end else if (accept && req_write && !req_err) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b])
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Response pipeline; data is already zero for stores,
  // errors and empty slots, so outputs need no masking
  always_comb begin
    pv_d = '0;
    pe_d = '0;
    for (int k = 0; k < LAT; k++)
      pd_d[k] = '0;
    pv_d[0] = accept;
    pe_d[0] = accept && req_err;
    if (accept && !req_write && !req_err)
      pd_d[0] = mem_q[req_idx];
    for (int k = 1; k < LAT; k++) begin
      pv_d[k] = pv_q[k-1];
      pe_d[k] = pe_q[k-1];
      pd_d[k] = pd_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int k = 0; k < LAT; k++)
        pd_q[k] <= '0;
    end else begin
      pv_q <= pv_d;
      pe_q <= pe_d;
      for (int k = 0; k < LAT; k++)
        pd_q[k] <= pd_d[k];
    end
  end

  assign rsp_valid = pv_q[LAT-1];
  assign rsp_error = pe_q[LAT-1];
  assign rsp_rdata = pd_q[LAT-1];

endmodule

// File: tb/tb_data_memory_bank.sv
// tb_data_memory_bank: directed + random stimulus against a byte-array
// reference model with an expected-response queue.
module tb_data_memory_bank;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NB-1:0] req_wstrb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          init_busy;

  data_memory_bank #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] bmem [DEPTH*NB];
  int         edge_cnt = 0;
  bit         mon_en = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
        chk("rsp_error", 64'(rsp_error), 64'(e.err));
      end else begin
        chk("idle_valid", 64'(rsp_valid), 64'd0);
        chk("idle_rdata", 64'(rsp_rdata), 64'd0);
        chk("idle_error", 64'(rsp_error), 64'd0);
      end
    end
  end

  function automatic bit is_err(input logic [31:0] a);
    bit e;
    e = (a >= 32'(DEPTH * NB));
`ifdef DMEM_MISALIGN_CHECK_EN
    e = e || (a % NB != 0);
`endif
    return e;
  endfunction

  task automatic issue(input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int   n;
    int   base;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.due  = edge_cnt + LAT - 1;
    e.err  = is_err(a);
    e.data = '0;
    base   = int'(a / NB) * NB;
    if (!e.err) begin
      if (w) begin
        for (int b = 0; b < NB; b++)
          if (s[b]) bmem[base+b] = d[8*b +: 8];
      end else begin
        for (int b = 0; b < NB; b++)
          e.data[8*b +: 8] = bmem[base+b];
      end
    end
    exp_q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    for (int i = 0; i < DEPTH*NB; i++) bmem[i] = 8'h00;
    mon_en = 1'b1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(init_busy), 64'd1);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = '0;
    n = 0;
    while (!req_ready && n < DEPTH + 50) begin
      chk("init_busy_hi", 64'(init_busy), 64'd1);
      @(posedge clk); #1;
      n++;
    end
    chk("init_len", 64'(n), 64'(DEPTH));
    chk("init_busy_lo", 64'(init_busy), 64'd0);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    do_reset();

    for (int i = 0; i < DEPTH; i++)
      issue(1'b0, 32'(i*NB), '0, '0);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h10, '0, '0);

    issue(1'b1, 32'h20, 32'h11223344, 4'hF);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'h20, '0, '0);

    issue(1'b0, 32'h40, '0, '0);
    issue(1'b0, 32'h1000, '0, '0);
    issue(1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
    issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    issue(1'b0, 32'h0, '0, '0);

    issue(1'b1, 32'h10, 32'h01020304, 4'h0);
    issue(1'b0, 32'h10, '0, '0);

    issue(1'b1, 32'h22, 32'h55667788, 4'hF);
    issue(1'b0, 32'h20, '0, '0);
    issue(1'b0, 32'h23, '0, '0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = $urandom_range(DEPTH*NB, 32'hFFFF);
      else
        a = $urandom_range(0, DEPTH*NB - 1);
      issue(1'($urandom_range(0, 1)), a, $urandom,
            4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    for (int i = 0; i < 4; i++)
      issue(1'b1, 32'(i*NB), $urandom | 32'h1, 4'hF);
    for (int i = 0; i < 4; i++)
      issue(1'b0, 32'(i*NB), '0, '0);
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      issue(1'b0, 32'(i*NB), '0, '0);

    repeat (LAT + 2) begin
      @(posedge clk); #1;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_bank.md
Name: data_memory_bank

Overview:
- Parametrised, single-port, byte-addressed data memory for the processor's load/store path. Successor to the fixed 1K x 32 data memory.
- Adds a request/response handshake, byte write strobes, a configurable read pipeline, out-of-range detection, and a post-reset clear sequence.
- Sits between the load/store unit and the memory array. The core stalls on `req_ready` low.

Parameters:
- DATA_WIDTH, 32, word width in bits; power of two, >= 8.
- DEPTH, 1024, number of words; power of two, >= 2.
- ADDR_WIDTH, 32, byte-address width; must be >= clog2(DEPTH) + clog2(DATA_WIDTH/8).
- READ_LATENCY, 1, cycles from accept to response; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- req_wstrb  in  DATA_WIDTH/8  byte write enables.
- rsp_valid  out  1  response pulse, one per accepted request.
- rsp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors.
- rsp_error  out  1  access out of range (or misaligned, see option).
- init_busy  out  1  clear sequence in progress.

Behaviour:
- Clock and reset: one clock, `clk`; reset is synchronous and active-high, port `reset`.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `init_busy`=1. The read pipeline is flushed and the FSM enters INIT.
- FSM states: INIT and RUN.
  - INIT: a counter walks index 0..DEPTH-1 and writes zero to one word per cycle. `req_ready`=0 and `init_busy`=1.
  - INIT -> RUN on the cycle after index DEPTH-1 is written, so INIT lasts exactly DEPTH cycles after reset deasserts.
  - RUN: `req_ready`=1 and `init_busy`=0. RUN -> INIT only on `reset`.
- Accept: a request is accepted on a rising edge with `req_valid` and `req_ready` both high. Single port, so at most one request per cycle.
- Address decode:
  - Word index = `req_addr`[clog2(DEPTH)+clog2(BYTES)-1 : clog2(BYTES)], where BYTES = DATA_WIDTH/8.
  - Low byte-offset bits are ignored.
  - Any nonzero bit above the index field marks the request out of range.
- Store:
  - Committed on the accepting edge. Byte i is updated only where `req_wstrb`[i]=1; other bytes are kept.
  - `wstrb`=0 performs no change but still gets a response.
  - An out-of-range store writes nothing.
- Load: the array is sampled on the accepting edge.
- Ordering: a load accepted in the cycle after a store to the same word returns the stored data. There is no same-cycle hazard.
- Response:
  - Every accepted request produces exactly one `rsp_valid` pulse, exactly READ_LATENCY cycles after acceptance. Example: accepted at edge N, `rsp_valid` is high during the cycle following edge N+READ_LATENCY-1.
  - Responses come back in order and are fully pipelined: back-to-back requests give back-to-back responses.
  - No response backpressure; the consumer must always take the response.
- Response data and flags:
  - Load, in range: `rsp_rdata` = stored word, `rsp_error`=0.
  - Store: `rsp_rdata`=0.
  - Error: `rsp_error`=1, `rsp_rdata`=0.
  - `rsp_rdata` and `rsp_error` return to 0 when `rsp_valid`=0.
- Reset mid-operation: in-flight responses are discarded with no `rsp_valid`. Array contents are re-cleared by INIT. A store accepted on the same edge that `reset` is sampled high is not committed.
- Requests presented while `req_ready`=0 are ignored; the requester must hold them until accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined: a request is misaligned when its byte-offset bits are nonzero. A misaligned request sets `rsp_error`=1 with `rsp_rdata`=0, and a misaligned store writes nothing. Response timing is unchanged.
- Undefined: offset bits are silently ignored and the access proceeds on the aligned word.

Test Plan:
- Reset, then count cycles with `req_valid` held high (DEPTH=16) -> `init_busy`=1 and `req_ready`=0 for exactly 16 cycles, then `req_ready`=1. Reading every word returns 0x00000000.
- Store 0xDEADBEEF to addr 0x10, then the next cycle load 0x10 (READ_LATENCY=2) -> load response 2 cycles after its accept with `rsp_rdata`=0xDEADBEEF and `rsp_error`=0. The store gets its own response 2 cycles after its accept with `rsp_rdata`=0.
- Prefill addr 0x20 with 0x11223344, store 0xAABBCCDD with `wstrb`=4'b0101, load 0x20 -> 0x11BB33DD.
- Load addr 0x1000 (DEPTH=1024, DATA_WIDTH=32, top valid byte address 0xFFF) -> `rsp_error`=1, `rsp_rdata`=0. A store to 0x1000 leaves word 0 unchanged.
- Four back-to-back loads of 0x0, 0x4, 0x8, 0xC, with `reset` asserted 1 cycle after the last accept (READ_LATENCY=3) -> pending responses suppressed, INIT re-runs, and the contents read back as 0.
- With DMEM_MISALIGN_CHECK_EN: store to 0x22 -> `rsp_error`=1 and word 0x20 unchanged. Without the macro, the same store updates word 0x20.
